calc_stage_pipe: RTL and testbench
==================================

// Module: calc_stage_pipe
// PURPOSE
//  Parametrised elastic pipeline register for the iteration engine's complex state (zr, zi)
//  plus a per-point tag. Generalises the single-register calc stage:
//  - configurable depth
//  - valid/ready back-pressure per stage
//  - global enable and synchronous flush
//  - occupancy count
//  Sits between the iteration datapath and its feedback/writeback so stages can stall independently.
// PARAMETERS
//  ENGINE_DATA_WIDTH  25  width of zr and zi (fixed-point, passed through untouched)
//  TAG_WIDTH          16  width of the pixel/point tag carried alongside z
//  DEPTH               2  number of register stages, >= 1; elaboration error if 0
// PORTS
//  clk        in   1                    clock, all state on rising edge
//  reset      in   1                    asynchronous, active-low reset
//  en         in   1                    global advance enable; 0 freezes every stage
//  flush      in   1                    synchronous clear of all stage valids
//  in_valid   in   1                    upstream presents zr_next/zi_next/tag_in
//  in_ready   out  1                    stage 0 can accept this cycle
//  zr_next    in   ENGINE_DATA_WIDTH    real part in
//  zi_next    in   ENGINE_DATA_WIDTH    imaginary part in
//  tag_in     in   TAG_WIDTH            tag in
//  out_valid  out  1                    last stage holds valid data
//  out_ready  in   1                    downstream accepts this cycle
//  zr         out  ENGINE_DATA_WIDTH    real part out (last stage register)
//  zi         out  ENGINE_DATA_WIDTH    imaginary part out
//  tag_out    out  TAG_WIDTH            tag out
//  occupancy  out  $clog2(DEPTH+1)      number of valid stages
//  stall_count out 32                   see CONFIGURATION
// BEHAVIOUR
//  - Reset (reset=0, async): all stage valids=0, all data regs=0; out_valid=0, zr=zi=tag_out=0.
//    occupancy=0, stall_count=0. in_ready=0 while reset is asserted.
//  - Stage k holds {v[k], zr, zi, tag}. rdy[DEPTH-1] = !v[DEPTH-1] | out_ready.
//    rdy[k] = !v[k] | rdy[k+1]. Ready chain is combinational: full throughput, no bubbles.
//  - in_ready = en & !flush & rdy[0]. Input accepted when in_valid & in_ready.
//  - Output handshake: transfer when out_valid & out_ready & en. out_valid = v[DEPTH-1] regardless of en.
//  - Stage k loads from k-1 (or input for k=0) when en & rdy[k]. v[k] <= v[k-1] (or in_valid&in_ready).
//    Data regs load only on an actual valid transfer; otherwise they hold (no toggling on bubbles).
//  - Latency: DEPTH cycles from acceptance to out_valid with en=1 and no stalls. Throughput 1/cycle.
//  - en=0: nothing moves, no transfer on either side, all regs hold. Outputs stay stable.
//  - flush=1 (priority over en and handshakes): next edge all v[k]=0, data regs hold.
//    Input that cycle is not accepted (in_ready=0); output that cycle does not count as consumed.
//  - Full: all v=1 & out_ready=0 -> in_ready=0, all stages hold. If out_ready=1, the whole pipe shifts,
//    in_ready=1 (simultaneous in/out; occupancy unchanged).
//  - Empty: occupancy=0, out_valid=0. A value in_valid at t appears at out_valid at t+DEPTH.
//  - occupancy = popcount(v), registered-state derived (combinational from v), range 0..DEPTH.
//  - Data widths pass through bit-exact; no arithmetic on zr/zi/tag.
//  - X on data inputs while in_valid=0 must never reach any register.
// CONFIGURATION
//  CALC_PIPE_STALL_STATS_EN defined:
//    stall_count increments (saturating at 2^32-1) every cycle with out_valid & !out_ready & en & !flush.
//    Clears only on reset.
//  CALC_PIPE_STALL_STATS_EN undefined: stall_count tied to 0, no counter logic synthesised.
// TESTING
//  1. DEPTH=3: reset release, feed zr=1..8, zi=-1..-8, tags 0..7 back-to-back, out_ready=1
//     -> first out_valid at cycle 3 after first accept; 8 outputs in order, no gaps.
//  2. DEPTH=3: fill with 3 items, out_ready=0 -> in_ready=0, occupancy=3.
//     Then out_ready=1 with in_valid=1 -> one item in and one out per cycle, occupancy stays 3.
//  3. en=0 for 5 cycles mid-stream with in_valid=out_ready=1 -> no transfers; outputs and occupancy frozen.
//     Resume matches the no-stall sequence.
//  4. flush with 2 items inside and in_valid=1 -> next cycle occupancy=0, out_valid=0.
//     Flushed and offered items never appear at the output.
//  5. Assert reset low mid-stream with 2 items inside -> immediately out_valid=0, zr=zi=tag_out=0,
//     occupancy=0. After release, a new item emerges after DEPTH cycles.
//  6. CALC_PIPE_STALL_STATS_EN, DEPTH=1: hold out_ready=0 for 7 cycles with out_valid=1 -> stall_count=7.
//     Without macro: stall_count=0.

Source files
------------

// File: rtl/calc_stage_pipe.sv
// Elastic multi-stage register for the iteration engine's complex state (zr, zi) plus tag.
// Optional stall statistics counter enabled by defining CALC_PIPE_STALL_STATS_EN.
module calc_stage_pipe #(
  parameter int ENGINE_DATA_WIDTH = 25,
  parameter int TAG_WIDTH         = 16,
  parameter int DEPTH             = 2,
  localparam int OCC_W            = (DEPTH < 1) ? 1 : $clog2(DEPTH + 1)
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                en,
  input  logic                                flush,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic signed [ENGINE_DATA_WIDTH-1:0] zr_next,
  input  logic signed [ENGINE_DATA_WIDTH-1:0] zi_next,
  input  logic        [TAG_WIDTH-1:0]         tag_in,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic signed [ENGINE_DATA_WIDTH-1:0] zr,
  output logic signed [ENGINE_DATA_WIDTH-1:0] zi,
  output logic        [TAG_WIDTH-1:0]         tag_out,
  output logic        [OCC_W-1:0]             occupancy,
  output logic        [31:0]                  stall_count
);

  if (DEPTH < 1) begin : g_bad_depth
    $error("calc_stage_pipe: DEPTH must be >= 1");
  end

  logic        [DEPTH-1:0]             vld_p;
  logic        [DEPTH-1:0]             rdy;
  logic        [DEPTH-1:0]             src_v;
  logic        [DEPTH-1:0]             ld;
  logic signed [ENGINE_DATA_WIDTH-1:0] zr_p   [DEPTH];
  logic signed [ENGINE_DATA_WIDTH-1:0] zi_p   [DEPTH];
  logic        [TAG_WIDTH-1:0]         tag_p  [DEPTH];
  logic signed [ENGINE_DATA_WIDTH-1:0] src_zr [DEPTH];
  logic signed [ENGINE_DATA_WIDTH-1:0] src_zi [DEPTH];
  logic        [TAG_WIDTH-1:0]         src_tag[DEPTH];
  logic                                accept;

  // A stage is ready if it is empty or anything downstream of it can move.
  always_comb begin : p_rdy
    logic r;
    rdy = '0;
    r   = ~vld_p[DEPTH-1] | out_ready;
    rdy[DEPTH-1] = r;
    for (int k = DEPTH - 2; k >= 0; k--) begin
      r      = ~vld_p[k] | r;
      rdy[k] = r;
    end
  end

  assign in_ready = reset & en & ~flush & rdy[0];
  assign accept   = in_valid & in_ready;

  always_comb begin
    src_v      = '0;
    src_v[0]   = accept;
    src_zr[0]  = zr_next;
    src_zi[0]  = zi_next;
    src_tag[0] = tag_in;
    for (int k = 1; k < DEPTH; k++) begin
      src_v[k]   = vld_p[k-1];
      src_zr[k]  = zr_p[k-1];
      src_zi[k]  = zi_p[k-1];
      src_tag[k] = tag_p[k-1];
    end
  end

  // Data moves only on a real valid transfer so bubbles never disturb the registers.
  always_comb begin
    ld = '0;
    for (int k = 0; k < DEPTH; k++) begin
      ld[k] = en & ~flush & rdy[k] & src_v[k];
    end
  end

  // Stage boundary: valid bits.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_p <= '0;
    end else if (flush) begin
      vld_p <= '0;
    end else if (en) begin
      for (int k = 0; k < DEPTH; k++) begin
        if (rdy[k]) vld_p[k] <= src_v[k];
      end
    end
  end

  // Stage boundary: payload registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < DEPTH; k++) begin
        zr_p[k]  <= '0;
        zi_p[k]  <= '0;
        tag_p[k] <= '0;
      end
    end else begin
      for (int k = 0; k < DEPTH; k++) begin
        if (ld[k]) begin
          zr_p[k]  <= src_zr[k];
          zi_p[k]  <= src_zi[k];
          tag_p[k] <= src_tag[k];
        end
      end
    end
  end

  assign out_valid = vld_p[DEPTH-1];
  assign zr        = zr_p[DEPTH-1];
  assign zi        = zi_p[DEPTH-1];
  assign tag_out   = tag_p[DEPTH-1];

  always_comb begin
    occupancy = '0;
    for (int k = 0; k < DEPTH; k++) begin
      occupancy = occupancy + OCC_W'(vld_p[k]);
    end
  end

`ifdef CALC_PIPE_STALL_STATS_EN
  logic [31:0] stall_cnt_q;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // Counts cycles where valid output is held back by downstream while the pipe is live.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_q <= '0;
    end else if (out_valid & ~out_ready & en & ~flush) begin
      stall_cnt_q <= sat_inc32(stall_cnt_q);
    end
  end

  assign stall_count = stall_cnt_q;
`else
  assign stall_count = '0;
`endif

endmodule

// File: tb/tb_calc_stage_pipe.sv
// Randomised scoreboard bench for calc_stage_pipe with an item-level elastic-queue model.
module tb_calc_stage_pipe;
  localparam int DW = 25;
  localparam int TW = 16;
  localparam int D  = 3;
  localparam int OW = $clog2(D + 1);

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          en = 1'b0;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic          in_ready;
  logic          out_valid;
  logic [DW-1:0] zr_next = '0;
  logic [DW-1:0] zi_next = '0;
  logic [TW-1:0] tag_in = '0;
  logic [DW-1:0] zr;
  logic [DW-1:0] zi;
  logic [TW-1:0] tag_out;
  logic [OW-1:0] occupancy;
  logic [31:0]   stall_count;

  calc_stage_pipe #(
    .ENGINE_DATA_WIDTH(DW),
    .TAG_WIDTH(TW),
    .DEPTH(D)
  ) dut (
    .clk(clk),
    .reset(reset),
    .en(en),
    .flush(flush),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .zr_next(zr_next),
    .zi_next(zi_next),
    .tag_in(tag_in),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .zr(zr),
    .zi(zi),
    .tag_out(tag_out),
    .occupancy(occupancy),
    .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] zr;
    logic [DW-1:0] zi;
    logic [TW-1:0] tag;
    int            pos;
  } item_t;

  item_t  inflight[$];
  item_t  exp_q[$];
  item_t  mon_item;
  int     n_cmp = 0;
  int     n_fail = 0;
  longint stall_m = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Compare against the model, then advance the model by one clock edge.
  task automatic check_and_advance();
    logic  ov_e;
    logic  ir_e;
    int    limit;
    item_t it;
    if (!reset) begin
      inflight.delete();
      exp_q.delete();
      stall_m = 0;
    end
    ov_e = (inflight.size() > 0) && (inflight[0].pos == D - 1);
    ir_e = reset && en && !flush && ((inflight.size() < D) || out_ready);
    chk("out_valid", longint'(out_valid), longint'(ov_e));
    chk("occupancy", longint'(occupancy), longint'(inflight.size()));
    chk("in_ready", longint'(in_ready), longint'(ir_e));
`ifdef CALC_PIPE_STALL_STATS_EN
    chk("stall_count", longint'(stall_count), stall_m);
`else
    chk("stall_count", longint'(stall_count), 0);
`endif
    if (!reset) begin
      chk("rst_zr", longint'(zr), 0);
      chk("rst_zi", longint'(zi), 0);
      chk("rst_tag", longint'(tag_out), 0);
    end else if (ov_e) begin
      chk("head_zr", longint'(zr), longint'(inflight[0].zr));
      chk("head_tag", longint'(tag_out), longint'(inflight[0].tag));
    end
    if (reset && flush) begin
      inflight.delete();
      exp_q.delete();
    end else if (reset && en) begin
      if (ov_e && !out_ready) stall_m++;
      if (in_valid && ir_e) begin
        it.zr  = zr_next;
        it.zi  = zi_next;
        it.tag = tag_in;
        it.pos = -1;
        inflight.push_back(it);
        exp_q.push_back(it);
      end
      if (ov_e && out_ready) void'(inflight.pop_front());
      limit = D;
      for (int i = 0; i < inflight.size(); i++) begin
        it = inflight[i];
        if (it.pos + 1 < limit) it.pos = it.pos + 1;
        inflight[i] = it;
        limit = it.pos;
      end
    end
  endtask

  task automatic step(input logic r, input logic e, input logic f, input logic iv,
                      input logic ordy, input logic [DW-1:0] a, input logic [DW-1:0] b,
                      input logic [TW-1:0] t);
    @(negedge clk);
    reset     = r;
    en        = e;
    flush     = f;
    in_valid  = iv;
    out_ready = ordy;
    zr_next   = a;
    zi_next   = b;
    tag_in    = t;
    #1;
    check_and_advance();
  endtask

  task automatic step_r(input logic r, input logic e, input logic f, input logic iv,
                        input logic ordy);
    step(r, e, f, iv, ordy, DW'($urandom), DW'($urandom), TW'($urandom));
  endtask

  task automatic drain();
    repeat (D + 2) step_r(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
  endtask

  // Scoreboard monitor: pops one expected item per observed output transfer.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (reset && en && !flush && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL sb_empty: output zr=%0d tag=%0d with nothing expected", zr, tag_out);
        end else begin
          mon_item = exp_q.pop_front();
          chk("sb_zr", longint'(zr), longint'(mon_item.zr));
          chk("sb_zi", longint'(zi), longint'(mon_item.zi));
          chk("sb_tag", longint'(tag_out), longint'(mon_item.tag));
        end
      end
    end
  end

  initial begin
    repeat (3) step_r(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);

    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, DW'(i + 1), DW'(-(i + 1)), TW'(i));
    end
    drain();

    repeat (4) step_r(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    repeat (5) step_r(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    drain();

    repeat (2) step_r(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    repeat (5) step_r(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    repeat (3) step_r(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    drain();

    repeat (2) step_r(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    step_r(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    step_r(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    drain();

    repeat (2) step_r(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    step_r(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    step_r(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    drain();

    step_r(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    repeat (D + 7) step_r(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    drain();

    repeat (400) begin
      step_r(1'b1, $urandom_range(0, 9) != 0, $urandom_range(0, 19) == 0,
             $urandom_range(0, 2) != 0, $urandom_range(0, 3) != 0);
    end
    drain();
    chk("drained", longint'(exp_q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
